// File: rtl/dz_pkg.sv
// Shared types and constants for the dot-matrix countdown controller.
// Holds the FSM state encoding, digit width and the largest displayable digit.
package dz_pkg;

   localparam int DZ_DIGIT_W = 3;

   localparam logic [DZ_DIGIT_W-1:0] DZ_MAX_DIGIT = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } dz_state_t;

   // Force the start digit into 1..DZ_MAX_DIGIT so the glyph set always covers it.
   function automatic logic [DZ_DIGIT_W-1:0] dz_legal_start(
      input logic [DZ_DIGIT_W-1:0] v
   );
      if (v == '0) begin
         return 3'd1;
      end else if (v > DZ_MAX_DIGIT) begin
         return DZ_MAX_DIGIT;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/dz_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level debouncer
// and a one-cycle pulse on each rising edge of the debounced level.
module dz_debounce
   import dz_pkg::*;
#(
   parameter int DEB_CYCLES = 20_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_rise
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // Bring the raw button into the clock domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else if (r_sync2 == r_level) begin
         r_cnt   <= '0;
      end else if (r_cnt == CNT_LAST) begin
         r_level <= r_sync2;
         r_cnt   <= '0;
      end else begin
         r_cnt   <= r_cnt + 1'b1;
      end
   end

   // Delayed copy of the level for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level_d <= 1'b0;
      end else begin
         r_level_d <= r_level;
      end
   end

   assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/dz_count_ctrl.sv
// Countdown controller for an 8x8 dot-matrix digit display.
// Debounced start/pause buttons drive an IDLE/RUN/PAUSE/DONE FSM.
module dz_count_ctrl
   import dz_pkg::*;
#(
   parameter int                    TICK_DIV   = 1_000_000,
   parameter int                    DEB_CYCLES = 20_000,
   parameter logic [DZ_DIGIT_W-1:0] START_VAL  = 3'd5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_start,
   input  logic                  btn_pause,
   output logic [DZ_DIGIT_W-1:0] num,
   output logic                  running,
   output logic                  done,
   output logic                  tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [DZ_DIGIT_W-1:0] START_C = dz_legal_start(START_VAL);

   dz_state_t             r_state;
   dz_state_t             w_state_n;
   logic [DZ_DIGIT_W-1:0] r_num;
   logic [DZ_DIGIT_W-1:0] w_num_n;
   logic [PW-1:0]         r_pre;
   logic [PW-1:0]         w_pre_n;
   logic                  r_tick;
   logic                  w_tick_n;
   logic                  w_start_p;
   logic                  w_pause_p;
   logic                  w_wrap;

   dz_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_start (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn_start),
      .o_rise (w_start_p)
   );

   dz_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb_pause (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn_pause),
      .o_rise (w_pause_p)
   );

   assign w_wrap = (r_pre == PRE_LAST);

   // State, digit, prescaler and tick registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_num   <= START_C;
         r_pre   <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_num   <= w_num_n;
         r_pre   <= w_pre_n;
         r_tick  <= w_tick_n;
      end
   end

   // Next-state logic; a pause without a wrap freezes the prescaler.
   always_comb begin
      w_state_n = r_state;
      w_num_n   = r_num;
      w_pre_n   = r_pre;
      w_tick_n  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_num_n = START_C;
            w_pre_n = '0;
            if (w_start_p) begin
               w_state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_wrap) begin
               w_pre_n = '0;
               if (r_num != '0) begin
                  w_num_n  = r_num - 1'b1;
                  w_tick_n = 1'b1;
               end
               if (r_num <= 3'd1) begin
                  w_state_n = ST_DONE;
               end else if (w_pause_p) begin
                  w_state_n = ST_PAUSE;
               end
            end else if (w_pause_p) begin
               w_state_n = ST_PAUSE;
            end else begin
               w_pre_n = r_pre + 1'b1;
            end
         end
         ST_PAUSE: begin
            if (w_start_p || w_pause_p) begin
               w_state_n = ST_RUN;
            end
         end
         ST_DONE: begin
            w_num_n = '0;
            w_pre_n = '0;
            if (w_start_p) begin
               w_state_n = ST_IDLE;
               w_num_n   = START_C;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_num_n   = START_C;
            w_pre_n   = '0;
         end
      endcase
   end

   assign num     = r_num;
   assign tick    = r_tick;
   assign running = (r_state == ST_RUN);
   assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_dz_count_ctrl.sv
// Self-checking bench for dz_count_ctrl (TICK_DIV=4, DEB_CYCLES=3, START_VAL=5).
// Expected digits are queued when stimulus is applied and popped on each tick.
module tb_dz_count_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_pause = 1'b0;
   logic [2:0] num;
   logic       running;
   logic       done;
   logic       tick;

   int checks = 0;
   int errors = 0;
   logic [2:0] sb_q[$];

   dz_count_ctrl #(
      .TICK_DIV   (4),
      .DEB_CYCLES (3),
      .START_VAL  (3'd5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_pause (btn_pause),
      .num       (num),
      .running   (running),
      .done      (done),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      btn_start = 1'b0;
      btn_pause = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(2);
      sb_q.delete();
   endtask

   task automatic wait_running(output int k);
      k = 0;
      while (running !== 1'b1 && k < 30) begin
         @(negedge clk);
         k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      cyc(2);
      checks++;
      if (num !== 3'd5) begin
         errors++;
         $display("FAIL reset_num: got %0d expected 5", num);
      end
      checks++;
      if ({running, done, tick} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {running, done, tick});
      end
      rst = 1'b1;
      cyc(2);
   endtask

   task automatic test_glitch();
      bit bad;
      do_reset();
      btn_start = 1'b1;
      cyc(1);
      btn_start = 1'b0;
      cyc(4);
      btn_start = 1'b1;
      cyc(2);
      btn_start = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (running !== 1'b0 || num !== 3'd5) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL glitch_ignored: running=%b num=%0d expected 0/5", running, num);
      end
   endtask

   task automatic test_full_count();
      int k;
      int last;
      logic [2:0] e;
      do_reset();
      btn_start = 1'b1;
      wait_running(k);
      checks++;
      if (k != 6) begin
         errors++;
         $display("FAIL start_latency: got %0d expected 6", k);
      end
      for (int v = 4; v >= 0; v--) sb_q.push_back(3'(v));
      last = 0;
      for (int c = 1; c <= 40 && sb_q.size() > 0; c++) begin
         @(negedge clk);
         if (c == 4) btn_start = 1'b0;
         if (tick === 1'b1) begin
            e = sb_q.pop_front();
            checks++;
            if (num !== e) begin
               errors++;
               $display("FAIL count_num: got %0d expected %0d", num, e);
            end
            checks++;
            if (c - last != 4) begin
               errors++;
               $display("FAIL tick_period: got %0d expected 4", c - last);
            end
            last = c;
         end
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL count_timeout: %0d ticks missing expected 0", sb_q.size());
         sb_q.delete();
      end
      checks++;
      if ({done, running, num} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL done_state: done=%b running=%b num=%0d expected 1/0/0", done, running, num);
      end
      @(negedge clk);
      checks++;
      if (tick !== 1'b0 || done !== 1'b1) begin
         errors++;
         $display("FAIL tick_one_cycle: tick=%b done=%b expected 0/1", tick, done);
      end
   endtask

   task automatic test_done_restart();
      int k;
      btn_start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 5) begin
            btn_start = 1'b0;
            checks++;
            if (done !== 1'b1) begin
               errors++;
               $display("FAIL done_hold: got %b expected 1", done);
            end
         end
      end
      checks++;
      if ({done, running, num} !== {1'b0, 1'b0, 3'd5}) begin
         errors++;
         $display("FAIL done_to_idle: done=%b running=%b num=%0d expected 0/0/5", done, running, num);
      end
      cyc(8);
      btn_start = 1'b1;
      wait_running(k);
      checks++;
      if (k != 6 || num !== 3'd5) begin
         errors++;
         $display("FAIL restart_run: latency=%0d num=%0d expected 6/5", k, num);
      end
      cyc(4);
      btn_start = 1'b0;
   endtask

   task automatic test_pause();
      int k;
      bit bad;
      logic [2:0] e;
      do_reset();
      btn_start = 1'b1;
      wait_running(k);
      sb_q.push_back(3'd4);
      sb_q.push_back(3'd3);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 3) btn_start = 1'b0;
         if (c == 5) btn_pause = 1'b1;
         if (tick === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL pause_extra_tick: got tick at %0d expected none", c);
            end else begin
               e = sb_q.pop_front();
               if (num !== e) begin
                  errors++;
                  $display("FAIL pause_count: got %0d expected %0d", num, e);
               end
            end
         end
      end
      checks++;
      if (running !== 1'b0 || num !== 3'd3 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL pause_enter: running=%b num=%0d pending=%0d expected 0/3/0", running, num, sb_q.size());
      end
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (i == 0) btn_pause = 1'b0;
         if (num !== 3'd3 || tick !== 1'b0 || running !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL pause_hold: num=%0d tick=%b expected 3/0", num, tick);
      end
      sb_q.delete();
      btn_pause = 1'b1;
      sb_q.push_back(3'd2);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 4) btn_pause = 1'b0;
         if (c == 5) begin
            checks++;
            if (running !== 1'b0) begin
               errors++;
               $display("FAIL resume_early: got running=%b expected 0", running);
            end
         end
         if (c == 6) begin
            checks++;
            if (running !== 1'b1 || num !== 3'd3) begin
               errors++;
               $display("FAIL resume: running=%b num=%0d expected 1/3", running, num);
            end
         end
         if (tick === 1'b1) begin
            checks++;
            if (sb_q.size() == 0 || c != 8) begin
               errors++;
               $display("FAIL resume_tick_time: got cycle %0d expected 8", c);
            end else begin
               e = sb_q.pop_front();
               if (num !== e) begin
                  errors++;
                  $display("FAIL resume_num: got %0d expected %0d", num, e);
               end
            end
         end
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL resume_timeout: %0d ticks missing expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_pause_wrap();
      int k;
      logic [2:0] e;
      do_reset();
      btn_start = 1'b1;
      wait_running(k);
      sb_q.push_back(3'd4);
      sb_q.push_back(3'd3);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 2) btn_pause = 1'b1;
         if (c == 3) btn_start = 1'b0;
         if (c == 6) btn_pause = 1'b0;
         if (tick === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL wrap_extra_tick: got tick at %0d expected none", c);
            end else begin
               e = sb_q.pop_front();
               if (num !== e) begin
                  errors++;
                  $display("FAIL wrap_count: got %0d expected %0d", num, e);
               end
            end
         end
      end
      checks++;
      if ({tick, running, done, num} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
         errors++;
         $display("FAIL pause_at_wrap: tick=%b running=%b done=%b num=%0d expected 1/0/0/3", tick, running, done, num);
      end
      cyc(6);
      checks++;
      if (num !== 3'd3 || running !== 1'b0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_paused_hold: num=%0d running=%b expected 3/0", num, running);
      end
   endtask

   task automatic test_reset_midrun();
      int k;
      bit bad;
      logic [2:0] e;
      do_reset();
      btn_start = 1'b1;
      wait_running(k);
      for (int v = 4; v >= 2; v--) sb_q.push_back(3'(v));
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (tick === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (num !== e) begin
               errors++;
               $display("FAIL midrun_count: got %0d expected %0d", num, e);
            end
         end
      end
      checks++;
      if (num !== 3'd2 || running !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre: num=%0d running=%b expected 2/1", num, running);
      end
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if ({num, running, done, tick} !== {3'd5, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: num=%0d running=%b done=%b tick=%b expected 5/0/0/0", num, running, done, tick);
      end
      cyc(2);
      rst = 1'b1;
      bad = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c <= 5 && (running !== 1'b0 || num !== 3'd5)) bad = 1'b1;
         if (c == 6) begin
            checks++;
            if (running !== 1'b1 || num !== 3'd5) begin
               errors++;
               $display("FAIL post_reset_start: running=%b num=%0d expected 1/5", running, num);
            end
         end
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL post_reset_early: running=%b expected 0 before latency", running);
      end
      btn_start = 1'b0;
   endtask

   task automatic test_both_idle();
      int k;
      do_reset();
      btn_start = 1'b1;
      btn_pause = 1'b1;
      wait_running(k);
      checks++;
      if (k != 6 || num !== 3'd5) begin
         errors++;
         $display("FAIL both_idle_run: latency=%0d num=%0d expected 6/5", k, num);
      end
      cyc(3);
      checks++;
      if (running !== 1'b1) begin
         errors++;
         $display("FAIL both_idle_stay: running=%b expected 1", running);
      end
      btn_start = 1'b0;
      btn_pause = 1'b0;
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_full_count();
      test_done_restart();
      test_pause();
      test_pause_wrap();
      test_reset_midrun();
      test_both_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dz_count_ctrl.md
DZ_COUNT_CTRL -- requirements
Module: dz_count_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1_000_000: clk cycles per count step (>=2).
REQ-002 SHALL have parameter DEB_CYCLES, default 20_000: cycles a raw button level must hold stable to be accepted (>=1).
REQ-003 SHALL have parameter START_VAL, default 3'd5: countdown start digit (legal 1..5; the 8x8 dot-matrix glyph set covers 0..5).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port btn_start, input, 1: raw asynchronous start/reload button, active-high.
REQ-007 SHALL have port btn_pause, input, 1: raw asynchronous pause/resume button, active-high.
REQ-008 SHALL have port num, output, 3: current digit, registered; drives the dot-matrix display's digit input.
REQ-009 SHALL have port running, output, 1: high while state is RUN.
REQ-010 SHALL have port done, output, 1: high while state is DONE.
REQ-011 SHALL have port tick, output, 1: one-cycle pulse in the same cycle num decrements.

Function
REQ-012 SHALL pass each button through a 2-flop synchronizer, then a debouncer: debounced level updates only after DEB_CYCLES consecutive equal synchronized samples; the counter clears on any sample mismatch.
REQ-013 SHALL derive start_p / pause_p as one-cycle pulses on the rising edge of each debounced level; holding a button yields exactly one pulse.
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE: num=START_VAL, prescaler=0; start_p -> RUN; pause_p ignored.
REQ-016 RUN: prescaler counts 0..TICK_DIV-1 and wraps; on wrap, num decrements and tick pulses; a decrement from 1 to 0 also transitions to DONE in the same edge.
REQ-017 RUN: pause_p -> PAUSE with prescaler frozen (not cleared); start_p alone in RUN is ignored.
REQ-018 RUN with pause_p in the same cycle as a wrap: the decrement and tick occur, then the state is PAUSE.
REQ-019 PAUSE: num and prescaler hold; pause_p or start_p -> RUN, resuming from the frozen prescaler value; both pulses together -> RUN.
REQ-020 DONE: num=0, done=1; start_p -> IDLE (reload num=START_VAL, prescaler=0); pause_p ignored.
REQ-021 IDLE with start_p and pause_p in the same cycle: start wins -> RUN.
REQ-022 num SHALL never decrement below 0 and never exceed START_VAL.
REQ-023 Prescaler width SHALL be clog2(TICK_DIV); debounce counter width SHALL be clog2(DEB_CYCLES+1).
REQ-024 Latency: a raw button edge SHALL produce a state change exactly 2 + DEB_CYCLES + 1 cycles later, given a stable input.

Reset
REQ-025 On rst low (asynchronous): state=IDLE, num=START_VAL, running=0, done=0, tick=0, prescaler=0, synchronizers/debounced levels/debounce counters=0.
REQ-026 Reset mid-RUN or mid-PAUSE SHALL discard all progress; after release, the first start_p begins a full count from START_VAL.
REQ-027 Reset release SHALL not create a spurious start_p / pause_p even if a button is held (debounced level rises only after DEB_CYCLES).

Structure
REQ-028 Package dz_pkg SHALL hold the FSM state typedef, constant DZ_MAX_DIGIT=3'd5, and the digit width (3).
REQ-029 Sub-module dz_debounce (synchronizer + debounce + rise-pulse) SHALL be instantiated once per button.
REQ-030 No combinational path from btn_* to any output.

Verification (TICK_DIV=4, DEB_CYCLES=3, START_VAL=5)
REQ-031 Reset, then start press held 10 cycles -> one start_p; running=1; num steps 5,4,3,2,1,0 every 4 cycles with tick each step; done=1 at num=0; running=0.
REQ-032 Start glitches of 1-2 cycles width -> no start_p, state stays IDLE, num=5.
REQ-033 Pause at prescaler=2 during num=3 -> num holds 3 for 50 cycles; resume -> next decrement 2 cycles later.
REQ-034 Pause pulse coincident with wrap at num=4 -> num=3, tick=1, state PAUSE.
REQ-035 In DONE, start press -> IDLE, num=5; second press -> RUN.
REQ-036 rst asserted mid-RUN at num=2 with btn_start held -> immediate IDLE, num=5; no start_p until held DEB_CYCLES after release.
